// File: rtl/pipe_sequencer.sv
// Pipeline controller for the 4-stage IF/ID/EX/WB datapath: stage enables,
// flush, valid tracking, write gating, forwarding, output handshake, debug FSM.
//
// state | meaning
// IDLE  | waiting for start, pipeline inert
// RUN   | free-running, advances unless output port blocks
// HALT  | debug halt, pipeline frozen
// STEP  | single debug advance, returns to HALT once it happens
module pipe_sequencer #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              step,
  input  logic              flush_req,
  input  logic              clr_cnt,
  input  logic [REG_AW-1:0] rs_idex,
  input  logic [REG_AW-1:0] rd_exwb,
  input  logic              reg_write_exwb,
  input  logic              output_sel_exwb,
  input  logic              out_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              rf_we,
  output logic              out_valid,
  output logic              fwd_sel,
  output logic [1:0]        state,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_STEP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [2:0]       v_q, v_d;       // [0]=ID, [1]=EX, [2]=WB
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             active, blocked, adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      v_q          <= 3'b000;
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    stall_cnt_d  = stall_cnt_q;
    retire_cnt_d = retire_cnt_q;

    active    = (state_q != S_IDLE);
    out_valid = v_q[2] & output_sel_exwb & ~flush_req & active;
    blocked   = out_valid & ~out_ready;
    adv       = ((state_q == S_RUN) | (state_q == S_STEP)) & ~blocked;

    pc_en      = adv;
    ifid_en    = adv;
    idex_en    = adv;
    exwb_en    = adv;
    ifid_flush = flush_req & active;
    idex_flush = flush_req & active;
    // A frozen WB instruction writes only on the cycle it finally leaves.
    rf_we      = v_q[2] & reg_write_exwb & adv & ~flush_req;
    fwd_sel    = v_q[1] & v_q[2] & reg_write_exwb & (rd_exwb == rs_idex);

    if (flush_req)
      v_d = 3'b000;
    else if (adv)
      v_d = {v_q[1], v_q[0], 1'b1};

    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (halt_req && !blocked) state_d = S_HALT;
      S_HALT: begin
        if (!halt_req)  state_d = S_RUN;
        else if (step)  state_d = S_STEP;
      end
      S_STEP: if (adv) state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (clr_cnt) begin
      stall_cnt_d  = '0;
      retire_cnt_d = '0;
    end else begin
      if (blocked && stall_cnt_q != CNT_MAX)
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (adv && v_q[2] && !flush_req && retire_cnt_q != CNT_MAX)
        retire_cnt_d = retire_cnt_q + 1'b1;
    end
  end

  assign state      = state_q;
  assign halted     = (state_q == S_HALT);
  assign stall_cnt  = stall_cnt_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: a cycle model of the sequencing rules checked on
// every cycle, plus directed scenarios with literal expectations.
module tb_pipe_sequencer;

  localparam int CW  = 4;
  localparam int AW  = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, start, halt_req, step, flush_req, clr_cnt;
  logic [AW-1:0] rs_idex, rd_exwb;
  logic          reg_write_exwb, output_sel_exwb, out_ready;
  logic          pc_en, ifid_en, idex_en, exwb_en, ifid_flush, idex_flush;
  logic          rf_we, out_valid, fwd_sel, halted;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_sequencer #(.CNT_W(CW), .REG_AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .step(step),
    .flush_req(flush_req), .clr_cnt(clr_cnt), .rs_idex(rs_idex), .rd_exwb(rd_exwb),
    .reg_write_exwb(reg_write_exwb), .output_sel_exwb(output_sel_exwb),
    .out_ready(out_ready), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exwb_en(exwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .rf_we(rf_we), .out_valid(out_valid), .fwd_sel(fwd_sel), .state(state),
    .halted(halted), .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state number, which of the three downstream slots (ID, EX, WB) hold
  // real instructions, and the two counters as plain integers.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_STEP = 3;
  int  m_state, m_stall, m_retire;
  bit  m_slot [3];
  bit  m_ok = 0;
  bit  e_ov, e_blk, e_adv, e_we, e_fwd, e_fl;

  always_comb begin
    e_ov  = m_slot[2] && output_sel_exwb && !flush_req && m_state != M_IDLE;
    e_blk = e_ov && !out_ready;
    e_adv = (m_state == M_RUN || m_state == M_STEP) && !e_blk;
    e_we  = m_slot[2] && reg_write_exwb && e_adv && !flush_req;
    e_fwd = m_slot[1] && m_slot[2] && reg_write_exwb && rd_exwb == rs_idex;
    e_fl  = flush_req && m_state != M_IDLE;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_ok     <= 1'b1;
      m_state  <= M_IDLE;
      m_stall  <= 0;
      m_retire <= 0;
      for (int i = 0; i < 3; i++) m_slot[i] <= 1'b0;
    end else begin
      if (flush_req)
        for (int i = 0; i < 3; i++) m_slot[i] <= 1'b0;
      else if (e_adv) begin
        // a new instruction enters ID, the rest move one slot downstream
        m_slot[0] <= 1'b1;
        m_slot[1] <= m_slot[0];
        m_slot[2] <= m_slot[1];
      end
      case (m_state)
        M_IDLE:  if (start) m_state <= M_RUN;
        M_RUN:   if (halt_req && !e_blk) m_state <= M_HALT;
        M_HALT:  m_state <= !halt_req ? M_RUN : (step ? M_STEP : M_HALT);
        default: if (e_adv) m_state <= M_HALT;
      endcase
      if (clr_cnt) begin
        m_stall  <= 0;
        m_retire <= 0;
      end else begin
        if (e_blk && m_stall < MAXC) m_stall <= m_stall + 1;
        if (e_adv && m_slot[2] && !flush_req && m_retire < MAXC) m_retire <= m_retire + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("pc_en",      int'(pc_en),      int'(e_adv));
      chk("ifid_en",    int'(ifid_en),    int'(e_adv));
      chk("idex_en",    int'(idex_en),    int'(e_adv));
      chk("exwb_en",    int'(exwb_en),    int'(e_adv));
      chk("ifid_flush", int'(ifid_flush), int'(e_fl));
      chk("idex_flush", int'(idex_flush), int'(e_fl));
      chk("rf_we",      int'(rf_we),      int'(e_we));
      chk("out_valid",  int'(out_valid),  int'(e_ov));
      chk("fwd_sel",    int'(fwd_sel),    int'(e_fwd));
      chk("state",      int'(state),      m_state);
      chk("halted",     int'(halted),     int'(m_state == M_HALT));
      chk("stall_cnt",  int'(stall_cnt),  m_stall);
      chk("retire_cnt", int'(retire_cnt), m_retire);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1; start = 0; halt_req = 0; step = 0; flush_req = 0; clr_cnt = 0;
    rs_idex = 0; rd_exwb = 1; reg_write_exwb = 1; output_sel_exwb = 0; out_ready = 1;
    tick(); tick();
    reset = 0;
    settle();
    chk("lit reset pc_en", int'(pc_en), 0);
    chk("lit reset state", int'(state), 0);

    // Fill: start, then 8 RUN cycles; WB becomes real on the 4th
    tick(); start = 1;
    settle();
    chk("lit idle pc_en", int'(pc_en), 0);
    tick(); start = 0;
    for (int i = 1; i <= 8; i++) begin
      settle();
      chk("lit fill pc_en", int'(pc_en), 1);
      chk("lit fill rf_we", int'(rf_we), int'(i >= 4));
      tick();
    end
    // Output blocked for 4 cycles then accepted
    output_sel_exwb = 1; out_ready = 0;
    settle();
    chk("lit retire after fill", int'(retire_cnt), 5);
    chk("lit blocked out_valid", int'(out_valid), 1);
    chk("lit blocked pc_en", int'(pc_en), 0);
    chk("lit blocked rf_we", int'(rf_we), 0);
    tick(); tick(); tick();
    tick(); out_ready = 1;
    settle();
    chk("lit stall after block", int'(stall_cnt), 4);
    chk("lit transfer rf_we", int'(rf_we), 1);
    chk("lit transfer pc_en", int'(pc_en), 1);
    tick(); output_sel_exwb = 0;
    settle();
    chk("lit retire after transfer", int'(retire_cnt), 6);

    // Halt, single step, resume
    halt_req = 1;
    tick();
    settle();
    chk("lit halt state", int'(state), 2);
    chk("lit halt halted", int'(halted), 1);
    chk("lit halt pc_en", int'(pc_en), 0);
    tick(); step = 1;
    tick(); step = 0;
    settle();
    chk("lit step state", int'(state), 3);
    chk("lit step pc_en", int'(pc_en), 1);
    tick();
    settle();
    chk("lit after step state", int'(state), 2);
    halt_req = 0;
    tick();
    settle();
    chk("lit resume state", int'(state), 1);

    // Flush during a blocked transfer
    tick(); output_sel_exwb = 1; out_ready = 0;
    tick();
    tick(); flush_req = 1;
    settle();
    chk("lit flush out_valid", int'(out_valid), 0);
    chk("lit flush ifid_flush", int'(ifid_flush), 1);
    chk("lit flush idex_flush", int'(idex_flush), 1);
    tick(); flush_req = 0; rd_exwb = 3; rs_idex = 3; reg_write_exwb = 1;
    settle();
    chk("lit post flush out_valid", int'(out_valid), 0);
    chk("lit post flush state", int'(state), 1);
    output_sel_exwb = 0; out_ready = 1;

    // Forwarding: EX real, WB still a bubble, then both real, then rd differs
    tick(); tick();
    settle();
    chk("lit fwd wb bubble", int'(fwd_sel), 0);
    tick();
    settle();
    chk("lit fwd match", int'(fwd_sel), 1);
    tick(); rd_exwb = 4;
    settle();
    chk("lit fwd rd differs", int'(fwd_sel), 0);
    rd_exwb = 3;

    // Stall counter saturation, then clear against a blocked cycle
    tick(); output_sel_exwb = 1; out_ready = 0;
    repeat (20) tick();
    settle();
    chk("lit stall saturated", int'(stall_cnt), 15);
    clr_cnt = 1;
    tick(); clr_cnt = 0;
    settle();
    chk("lit clr stall", int'(stall_cnt), 0);
    chk("lit clr retire", int'(retire_cnt), 0);

    // Reset taken while held in STEP by a blocked output
    output_sel_exwb = 0; out_ready = 1; halt_req = 1;
    tick(); output_sel_exwb = 1; out_ready = 0; step = 1;
    tick(); step = 0;
    settle();
    chk("lit step held state", int'(state), 3);
    tick();
    settle();
    chk("lit step still held", int'(state), 3);
    reset = 1;
    tick(); reset = 0; halt_req = 0;
    settle();
    chk("lit reset in step state", int'(state), 0);
    chk("lit reset in step stall", int'(stall_cnt), 0);
    chk("lit reset in step retire", int'(retire_cnt), 0);
    chk("lit reset in step out_valid", int'(out_valid), 0);
    tick(); tick();
    settle();
    chk("lit idle holds", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
- Central controller for the 4-stage 8-bit pipeline (IF, ID, EX, WB).
- Generates stage-register enables and bubble/flush controls, tracks per-stage valid bits, and gates register-file writes.
- Provides EX-stage forwarding select, the output-port valid/ready handshake, debug run/halt/single-step, and stall/retire counters.

Parameters:
CNT_W, 16, width of stall_cnt and retire_cnt (saturating)
REG_AW, 3, register-address width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  leave IDLE and begin execution
halt_req  in  1  level; request debug halt
step  in  1  pulse; in HALT, advance pipeline exactly one cycle
flush_req  in  1  pulse; kill all in-flight instructions
clr_cnt  in  1  synchronous clear of both counters
rs_idex  in  REG_AW  source register of instruction in EX
rd_exwb  in  REG_AW  destination register of instruction in WB
reg_write_exwb  in  1  WB instruction writes register file
output_sel_exwb  in  1  WB instruction drives output port
out_ready  in  1  output-port consumer ready
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register enable
idex_en  out  1  ID/EX register enable
exwb_en  out  1  EX/WB register enable
ifid_flush  out  1  load bubble into IF/ID
idex_flush  out  1  load bubble into ID/EX
rf_we  out  1  gated register-file write enable
out_valid  out  1  output-port data valid
fwd_sel  out  1  1 = EX operand A taken from WB result
state  out  2  0 IDLE, 1 RUN, 2 HALT, 3 STEP
halted  out  1  state==HALT
stall_cnt  out  CNT_W  cycles blocked on output port
retire_cnt  out  CNT_W  instructions retired

Behaviour:
- Reset (sync, high): state=IDLE, v_id=v_ex=v_wb=0, both counters 0.
  - All outputs are then 0: enables, flushes, rf_we, out_valid, fwd_sel, halted.
- Internal valid bits v_id, v_ex, v_wb mark real instructions in ID, EX and WB.
- Combinational terms:
  - out_valid = v_wb & output_sel_exwb & ~flush_req & (state!=IDLE).
  - blocked = out_valid & ~out_ready.
  - adv = (state==RUN | state==STEP) & ~blocked.
  - pc_en = ifid_en = idex_en = exwb_en = adv. The whole pipeline freezes together; no partial advance.
  - rf_we = v_wb & reg_write_exwb & adv & ~flush_req. Bubbles never write; a frozen instruction writes once, on its leaving cycle.
  - fwd_sel = v_ex & v_wb & reg_write_exwb & (rd_exwb==rs_idex).
  - ifid_flush = idex_flush = flush_req & (state!=IDLE).
- Valid bits:
  - On adv: v_id<=1, v_ex<=v_id, v_wb<=v_ex.
  - flush_req overrides: all three bits <=0 in the same cycle, even if adv=1.
  - Otherwise the bits hold.
- Output handshake:
  - Transfer occurs when out_valid & out_ready.
  - While blocked, out_valid stays high and the WB instruction is held.
  - flush_req cancels a pending transfer: out_valid=0 that cycle.
- FSM transitions:
  - IDLE: start -> RUN; everything else ignored.
  - RUN: halt_req & ~blocked -> HALT, after this cycle's advance. halt_req & blocked -> remain RUN until unblocked.
  - HALT: ~halt_req -> RUN; halt_req & step -> STEP; else stay. No advance in HALT.
  - STEP: adv -> HALT (exactly one advance); blocked -> stay in STEP.
- flush_req never changes state.
- Counters:
  - stall_cnt +1 per cycle with blocked=1.
  - retire_cnt +1 per cycle with adv & v_wb & ~flush_req.
  - Both saturate at all-ones. clr_cnt zeroes both and beats an increment in the same cycle.
- Reset mid-operation (any state, any pending transfer): all of the above returns to reset values next edge; a pending output is dropped.

Test Plan:
1. Reset -> start at cycle 0 -> enables=1 from cycle 1; v_wb first 1 after 3 advances; rf_we=0 during the 3 fill cycles; retire_cnt=5 after 8 RUN cycles.
2. output_sel_exwb=1 with v_wb=1, out_ready=0 for 4 cycles, then 1 -> all enables 0 for 4 cycles; out_valid held high; exactly one transfer; stall_cnt=4; rf_we pulses once.
3. halt_req=1 in RUN -> HALT next cycle, enables 0. Then step pulse -> STEP with one adv cycle, then HALT. Then halt_req=0 -> RUN.
4. flush_req during a blocked output transfer -> out_valid=0, ifid_flush=idex_flush=1; v bits all 0 next cycle; state unchanged; no further output from the flushed instruction.
5. rd_exwb=3, rs_idex=3, reg_write_exwb=1, v_ex=v_wb=1 -> fwd_sel=1. Same with v_wb=0 or rd_exwb=4 -> fwd_sel=0.
6. Counter corners:
   - CNT_W=4, hold blocked 20 cycles -> stall_cnt=15 (saturated).
   - clr_cnt coincident with a blocked cycle -> stall_cnt=0.
   - reset asserted in STEP -> IDLE, counters 0.
